// File: rtl/pipelined_subtractor_64_if.sv
// Operand/result stream bundle for the 64-bit pipelined subtractor.
// The slave side is the subtractor; the master side is whoever feeds and drains it.
interface pipelined_subtractor_64_if;
  logic [63:0] i_a;
  logic [63:0] i_b;
  logic        i_borrow_in;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [63:0] o_diff;
  logic        o_borrow_out;
  logic        o_overflow;
  logic        o_zero;
  logic        o_out_valid;
  logic        i_out_ready;

  modport master (
    output i_a, i_b, i_borrow_in, i_in_valid, i_out_ready,
    input  o_in_ready, o_diff, o_borrow_out, o_overflow, o_zero, o_out_valid
  );

  modport slave (
    input  i_a, i_b, i_borrow_in, i_in_valid, i_out_ready,
    output o_in_ready, o_diff, o_borrow_out, o_overflow, o_zero, o_out_valid
  );
endinterface

// File: rtl/pipelined_subtractor_64.sv
// Four-stage 64-bit subtractor (A - B - borrow_in) computed as A + ~B + carry,
// one 16-bit slice per stage, with a valid/ready elastic pipeline.
module pipelined_subtractor_64 (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  pipelined_subtractor_64_if.slave        sub_if
);

  logic [3:0]  r_valid;
  logic [4:0]  w_rdy;
  logic [3:0]  w_vin;
  logic [3:0]  w_load;
  logic [63:0] w_nb;

  // Stage registers: partial difference, carry, and the not-yet-processed slices.
  logic [15:0] r_diff0;
  logic        r_c0;
  logic [47:0] r_a0;
  logic [47:0] r_nb0;
  logic [31:0] r_diff1;
  logic        r_c1;
  logic [31:0] r_a1;
  logic [31:0] r_nb1;
  logic [47:0] r_diff2;
  logic        r_c2;
  logic [15:0] r_a2;
  logic [15:0] r_nb2;
  logic [63:0] r_diff;
  logic        r_borrow_out;
  logic        r_overflow;
  logic        r_zero;

  logic [16:0] w_sum0;
  logic [16:0] w_sum1;
  logic [16:0] w_sum2;
  logic [16:0] w_sum3;
  logic [63:0] w_diff3;

  assign w_nb     = ~sub_if.i_b;
  assign w_rdy[4] = sub_if.i_out_ready;
  assign w_vin    = {r_valid[2:0], sub_if.i_in_valid};

  // A stage can take new contents when it is empty or its occupant moves on.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ctrl
      assign w_rdy[gi]  = !r_valid[gi] || w_rdy[gi+1];
      assign w_load[gi] = w_rdy[gi] && w_vin[gi];

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_valid[gi] <= 1'b0;
        end else if (w_rdy[gi]) begin
          r_valid[gi] <= w_vin[gi];
        end
      end
    end
  endgenerate

  assign w_sum0  = {1'b0, sub_if.i_a[15:0]} + {1'b0, w_nb[15:0]} + {16'd0, !sub_if.i_borrow_in};
  assign w_sum1  = {1'b0, r_a0[15:0]} + {1'b0, r_nb0[15:0]} + {16'd0, r_c0};
  assign w_sum2  = {1'b0, r_a1[15:0]} + {1'b0, r_nb1[15:0]} + {16'd0, r_c1};
  assign w_sum3  = {1'b0, r_a2} + {1'b0, r_nb2} + {16'd0, r_c2};
  assign w_diff3 = {w_sum3[15:0], r_diff2};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_diff0      <= '0;
      r_c0         <= 1'b0;
      r_a0         <= '0;
      r_nb0        <= '0;
      r_diff1      <= '0;
      r_c1         <= 1'b0;
      r_a1         <= '0;
      r_nb1        <= '0;
      r_diff2      <= '0;
      r_c2         <= 1'b0;
      r_a2         <= '0;
      r_nb2        <= '0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
      r_overflow   <= 1'b0;
      r_zero       <= 1'b0;
    end else begin
      if (w_load[0]) begin
        r_diff0 <= w_sum0[15:0];
        r_c0    <= w_sum0[16];
        r_a0    <= sub_if.i_a[63:16];
        r_nb0   <= w_nb[63:16];
      end
      if (w_load[1]) begin
        r_diff1 <= {w_sum1[15:0], r_diff0};
        r_c1    <= w_sum1[16];
        r_a1    <= r_a0[47:16];
        r_nb1   <= r_nb0[47:16];
      end
      if (w_load[2]) begin
        r_diff2 <= {w_sum2[15:0], r_diff1};
        r_c2    <= w_sum2[16];
        r_a2    <= r_a1[31:16];
        r_nb2   <= r_nb1[31:16];
      end
      // Operand sign bits differ exactly when A[63] equals ~B[63].
      if (w_load[3]) begin
        r_diff       <= w_diff3;
        r_borrow_out <= !w_sum3[16];
        r_overflow   <= (r_a2[15] == r_nb2[15]) && (w_diff3[63] != r_a2[15]);
        r_zero       <= (w_diff3 == 64'd0);
      end
    end
  end

  assign sub_if.o_in_ready   = w_rdy[0];
  assign sub_if.o_out_valid  = r_valid[3];
  assign sub_if.o_diff       = r_diff;
  assign sub_if.o_borrow_out = r_borrow_out;
  assign sub_if.o_overflow   = r_overflow;
  assign sub_if.o_zero       = r_zero;

endmodule

// File: doc/pipelined_subtractor_64.md
PIPELINED_SUBTRACTOR_64 -- requirements
Module: pipelined_subtractor_64

Interface
REQ-001 The block SHALL have no parameters; width is fixed at 64 bits, split into four 16-bit slices.
REQ-002 CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 A  input  64  minuend, sampled on input handshake.
REQ-005 B  input  64  subtrahend, sampled on input handshake.
REQ-006 BORROW_IN  input  1  borrow-in, subtracted from the result.
REQ-007 IN_VALID  input  1  operands valid.
REQ-008 IN_READY  output  1  block can accept operands this cycle.
REQ-009 DIFF  output  64  result A - B - BORROW_IN, modulo 2^64.
REQ-010 BORROW_OUT  output  1  1 when unsigned A < B + BORROW_IN.
REQ-011 OVERFLOW  output  1  signed two's-complement overflow of the subtraction.
REQ-012 ZERO  output  1  1 when DIFF == 0.
REQ-013 OUT_VALID  output  1  result outputs valid.
REQ-014 OUT_READY  input  1  downstream accepts result this cycle.

Function
REQ-015 Input handshake SHALL occur on a rising edge with IN_VALID=1 and IN_READY=1; output handshake SHALL occur with OUT_VALID=1 and OUT_READY=1.
REQ-016 Arithmetic SHALL be computed as A + ~B + carry, with stage-0 carry-in = !BORROW_IN and BORROW_OUT = !(final carry out of bit 63).
REQ-017 Stage k (k=0..3) SHALL compute bits [16k+15:16k] using the carry registered by stage k-1, and SHALL forward the remaining unprocessed operand slices unchanged.
REQ-018 Each stage SHALL hold a valid bit, a partial DIFF, the inter-slice carry, and the remaining A/~B slices; no slice SHALL be computed twice.
REQ-019 OVERFLOW SHALL be computed in stage 3 as (A[63] != B[63]) && (DIFF[63] != A[63]).
REQ-020 ZERO SHALL be computed in stage 3 from the full 64-bit DIFF.
REQ-021 Latency SHALL be exactly 4 cycles from input handshake to OUT_VALID=1 when OUT_READY is held high.
REQ-022 Throughput SHALL be one operation per cycle when OUT_READY is held high.
REQ-023 Stage k SHALL load from stage k-1 (or from the inputs, for k=0) when stage k is empty or stage k is advancing this cycle.
REQ-024 Stage 3 advances on an output handshake.
REQ-025 IN_READY SHALL be combinationally (stage-0 empty) OR (stage 0 advancing); it SHALL NOT depend on IN_VALID.
REQ-026 A stage that is not loaded and not advancing SHALL hold its contents, so bubbles collapse under backpressure.
REQ-027 While OUT_VALID=1 and OUT_READY=0, DIFF, BORROW_OUT, OVERFLOW and ZERO SHALL remain stable.
REQ-028 Results SHALL emerge in input-handshake order; no operation SHALL be dropped or duplicated.
REQ-029 Simultaneous input and output handshakes on a full pipeline SHALL both complete in the same cycle.
REQ-030 When OUT_VALID=0, the data outputs SHALL be don't-care to downstream, but SHALL be deterministic (retain their last values).

Reset
REQ-031 RST_N=0 SHALL immediately clear all stage valid bits, OUT_VALID, DIFF, BORROW_OUT, OVERFLOW, ZERO and all internal carries to 0.
REQ-032 While RST_N=0, IN_READY SHALL read 1 (pipeline empty).
REQ-033 Operations in flight at reset assertion SHALL be discarded with no output produced.
REQ-034 The first input handshake SHALL be possible on the first rising edge after RST_N deasserts.

Verification
REQ-035 A=0, B=1, BORROW_IN=0 -> after 4 cycles DIFF=FFFF_FFFF_FFFF_FFFF, BORROW_OUT=1, OVERFLOW=0, ZERO=0.
REQ-036 A=8000_0000_0000_0000, B=1, BORROW_IN=0 -> DIFF=7FFF_FFFF_FFFF_FFFF, OVERFLOW=1, BORROW_OUT=0.
REQ-037 Borrow chain and zero checks:
- A=0000_0001_0000_0000, B=0, BORROW_IN=1 -> DIFF=0000_0000_FFFF_FFFF, BORROW_OUT=0 (borrow crosses slices 0-1).
- A=B=0123_4567_89AB_CDEF, BORROW_IN=0 -> DIFF=0, ZERO=1.
REQ-038 Backpressure: issue 6 back-to-back operations with OUT_READY=0 for 8 cycles, then release.
- IN_READY SHALL drop after 4 accepts.
- The 6 results SHALL emerge in order, each matching a reference model, with outputs stable while stalled.
REQ-039 Reset mid-operation: accept 3 operations, assert RST_N=0 for 1 cycle on cycle 2 -> OUT_VALID=0 immediately, no result from those operations ever appears, and a new operation after reset completes in 4 cycles.
REQ-040 Random regression: at least 100k random A, B, BORROW_IN values with random IN_VALID/OUT_READY -> every output matches the reference model, none lost or reordered.
